// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and widths for the CNN image feeder.
package cnn_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned N_PIX     = 784;
    localparam int unsigned CLR_CYC   = 2;
    localparam int unsigned TIMEOUT   = 4095;

    localparam int unsigned ADDR_W = $clog2(N_PIX);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned CLR_W  = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam int unsigned DEC_W  = 4;

    localparam logic [DEC_W-1:0] DEC_TIMEOUT = 4'hF;

    typedef enum logic [2:0] {
        LOAD,
        READY,
        CLEAR,
        STREAM,
        WAIT,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/pix_buf.sv
// Frame pixel buffer: one write port, one registered read port that doubles as the core's data_in driver.
module pix_buf
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic                 rd_clr,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem [N_PIX];

    // Storage array carries no reset; contents are defined only after a load.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register returns to zero whenever no pixel is being streamed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cnn_img_feeder.sv
// Loads one 28x28 frame, resets the CNN core, streams one pixel per clock and holds the decision until acked.
module cnn_img_feeder
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_ready,
    input  logic                 start,
    output logic                 busy,
    output logic                 chip_rst_n,
    output logic [DATA_BITS-1:0] data_out,
    input  logic                 valid_out_6,
    input  logic [DEC_W-1:0]     decision,
    output logic [DEC_W-1:0]     result,
    output logic                 result_valid,
    output logic                 timeout_err,
    input  logic                 result_ack
);

    feeder_state_t     state, state_nxt;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
    logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
    logic [CLR_W-1:0]  clr_cnt, clr_cnt_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic              early, early_nxt;
    logic              wr_ready_nxt, busy_nxt, chip_rst_n_nxt;
    logic [DEC_W-1:0]  result_nxt;
    logic              result_valid_nxt, timeout_err_nxt;
    logic              buf_wr_en, buf_rd_en, buf_rd_clr;

    pix_buf u_pix_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (buf_rd_en),
        .rd_clr  (buf_rd_clr),
        .rd_addr (rd_addr),
        .rd_data (data_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD;
            wr_addr      <= '0;
            rd_addr      <= '0;
            clr_cnt      <= '0;
            to_cnt       <= '0;
            early        <= 1'b0;
            wr_ready     <= 1'b1;
            busy         <= 1'b0;
            chip_rst_n   <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            wr_addr      <= wr_addr_nxt;
            rd_addr      <= rd_addr_nxt;
            clr_cnt      <= clr_cnt_nxt;
            to_cnt       <= to_cnt_nxt;
            early        <= early_nxt;
            wr_ready     <= wr_ready_nxt;
            busy         <= busy_nxt;
            chip_rst_n   <= chip_rst_n_nxt;
            result       <= result_nxt;
            result_valid <= result_valid_nxt;
            timeout_err  <= timeout_err_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        wr_addr_nxt      = wr_addr;
        rd_addr_nxt      = rd_addr;
        clr_cnt_nxt      = clr_cnt;
        to_cnt_nxt       = to_cnt;
        early_nxt        = early;
        chip_rst_n_nxt   = chip_rst_n;
        result_nxt       = result;
        result_valid_nxt = result_valid;
        timeout_err_nxt  = timeout_err;
        buf_wr_en        = 1'b0;
        buf_rd_en        = 1'b0;
        buf_rd_clr       = 1'b0;

        case (state)
            LOAD: begin
                if (wr_valid && wr_ready) begin
                    buf_wr_en = 1'b1;
                    if (wr_addr == ADDR_W'(N_PIX - 1)) begin
                        wr_addr_nxt = '0;
                        state_nxt   = READY;
                    end else begin
                        wr_addr_nxt = wr_addr + ADDR_W'(1);
                    end
                end
            end
            READY: begin
                if (start) begin
                    state_nxt      = CLEAR;
                    chip_rst_n_nxt = 1'b0;
                    clr_cnt_nxt    = '0;
                    rd_addr_nxt    = '0;
                    to_cnt_nxt     = '0;
                    early_nxt      = 1'b0;
                end
            end
            CLEAR: begin
                rd_addr_nxt = '0;
                to_cnt_nxt  = '0;
                // Last reset cycle prefetches pixel 0 so it appears as the core leaves reset.
                if (clr_cnt == CLR_W'(CLR_CYC - 1)) begin
                    buf_rd_en      = 1'b1;
                    rd_addr_nxt    = ADDR_W'(1);
                    chip_rst_n_nxt = 1'b1;
                    state_nxt      = STREAM;
                end else begin
                    clr_cnt_nxt = clr_cnt + CLR_W'(1);
                end
            end
            STREAM: begin
                if (valid_out_6 && !early) begin
                    result_nxt = decision;
                    early_nxt  = 1'b1;
                end
                // rd_addr runs one ahead of the pixel on data_out.
                if (rd_addr == ADDR_W'(N_PIX)) begin
                    buf_rd_clr = 1'b1;
                    if (early_nxt) begin
                        result_valid_nxt = 1'b1;
                        state_nxt        = DONE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else begin
                    buf_rd_en   = 1'b1;
                    rd_addr_nxt = rd_addr + ADDR_W'(1);
                end
            end
            WAIT: begin
                to_cnt_nxt = to_cnt + TO_W'(1);
                if (valid_out_6) begin
                    result_nxt       = decision;
                    result_valid_nxt = 1'b1;
                    state_nxt        = DONE;
                end else if (to_cnt_nxt == TO_W'(TIMEOUT)) begin
                    result_nxt       = DEC_TIMEOUT;
                    timeout_err_nxt  = 1'b1;
                    result_valid_nxt = 1'b1;
                    state_nxt        = DONE;
                end
            end
            DONE: begin
                if (result_ack) begin
                    result_valid_nxt = 1'b0;
                    timeout_err_nxt  = 1'b0;
                    state_nxt        = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase

        wr_ready_nxt = (state_nxt == LOAD);
        busy_nxt     = (state_nxt == CLEAR) || (state_nxt == STREAM) || (state_nxt == WAIT);
    end

endmodule

// File: tb/tb_cnn_img_feeder.sv
// Self-checking bench for cnn_img_feeder with a stub CNN core driving valid_out_6/decision.
module tb_cnn_img_feeder;
    import cnn_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 wr_valid = 1'b0;
    logic [DATA_BITS-1:0] wr_data = '0;
    logic                 wr_ready;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 chip_rst_n;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid_out_6 = 1'b0;
    logic [3:0]           decision = 4'h0;
    logic [3:0]           result;
    logic                 result_valid;
    logic                 timeout_err;
    logic                 result_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [DATA_BITS-1:0] exp_q[$];

    typedef struct {
        int         frame;
        int         early_pix;   // -1: no early decision
        int         wait_dly;    // -1: never answer in WAIT
        logic [3:0] dec;
        logic [3:0] exp_result;
        logic       exp_to;
        bit         start_in_load;
        bit         junk_ready;
    } vec_t;

    vec_t vecs[6];

    cnn_img_feeder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .start        (start),
        .busy         (busy),
        .chip_rst_n   (chip_rst_n),
        .data_out     (data_out),
        .valid_out_6  (valid_out_6),
        .decision     (decision),
        .result       (result),
        .result_valid (result_valid),
        .timeout_err  (timeout_err),
        .result_ack   (result_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int f, input int i);
        if (f == 0) return 8'(i);
        return 8'(i * 7 + f * 29 + (i >> 5));
    endfunction

    task automatic load_frame(input int f, input bit start_in_load, input bit junk);
        for (int i = 0; i < int'(N_PIX); i++) begin
            @(negedge clk);
            if (i == 0) chk("wr_ready_load", 32'(wr_ready), 32'd1);
            if (i == 501 && start_in_load) chk("busy_start_in_load", 32'(busy), 32'd0);
            wr_valid = 1'b1;
            wr_data  = pix(f, i);
            start    = start_in_load && (i == 500);
            exp_q.push_back(pix(f, i));
        end
        @(negedge clk);
        wr_valid = junk;
        wr_data  = 8'hA5;
        start    = 1'b0;
        chk("wr_ready_ready", 32'(wr_ready), 32'd0);
        chk("busy_ready", 32'(busy), 32'd0);
        if (junk) begin
            repeat (4) begin
                @(negedge clk);
                wr_data = ~wr_data;
            end
            chk("wr_ready_junk", 32'(wr_ready), 32'd0);
        end
        wr_valid = 1'b0;
    endtask

    task automatic start_and_clear();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("chip_rst_clr0", 32'(chip_rst_n), 32'd0);
        chk("busy_clear", 32'(busy), 32'd1);
        @(negedge clk);
        chk("chip_rst_clr1", 32'(chip_rst_n), 32'd0);
        chk("data_out_clear", 32'(data_out), 32'd0);
        @(negedge clk);
        chk("chip_rst_stream", 32'(chip_rst_n), 32'd1);
    endtask

    task automatic check_pixel(input int k);
        logic [DATA_BITS-1:0] e;
        if (exp_q.size() == 0) begin
            chk("pix_queue_empty", 32'(k), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            if (data_out !== e)
                $display("FAIL pixel[%0d]: got %0h expected %0h", k, data_out, e);
            checks++;
            if (data_out !== e) errors++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        load_frame(v.frame, v.start_in_load, v.junk_ready);
        start_and_clear();
        for (int k = 0; k < int'(N_PIX); k++) begin
            if (k > 0) @(negedge clk);
            check_pixel(k);
            if (k == v.early_pix) begin
                valid_out_6 = 1'b1;
                decision    = v.dec;
            end else begin
                valid_out_6 = 1'b0;
                decision    = 4'h1;
            end
        end
        @(negedge clk);
        valid_out_6 = 1'b0;
        chk("data_out_after", 32'(data_out), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        if (v.early_pix < 0) begin
            chk("busy_wait", 32'(busy), 32'd1);
            chk("rv_wait", 32'(result_valid), 32'd0);
            if (v.wait_dly < 0) begin
                n = 0;
                while (!result_valid && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                chk("timeout_cycles", 32'(n), 32'(TIMEOUT));
            end else begin
                repeat (v.wait_dly) @(negedge clk);
                chk("rv_before_dec", 32'(result_valid), 32'd0);
                valid_out_6 = 1'b1;
                decision    = v.dec;
                @(negedge clk);
                valid_out_6 = 1'b0;
                decision    = 4'h1;
            end
        end
        chk("result_valid", 32'(result_valid), 32'd1);
        chk("result", 32'(result), 32'(v.exp_result));
        chk("timeout_err", 32'(timeout_err), 32'(v.exp_to));
        chk("busy_done", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("result_hold", 32'(result), 32'(v.exp_result));
        chk("rv_hold", 32'(result_valid), 32'd1);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        chk("rv_acked", 32'(result_valid), 32'd0);
        chk("to_acked", 32'(timeout_err), 32'd0);
        chk("wr_ready_acked", 32'(wr_ready), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_chip_rst_n"}, 32'(chip_rst_n), 32'd0);
        chk({tag, "_data_out"}, 32'(data_out), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_rv"}, 32'(result_valid), 32'd0);
        chk({tag, "_to"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        vecs[0] = '{frame: 0, early_pix: -1,  wait_dly: 5,  dec: 4'd2,  exp_result: 4'd2,  exp_to: 1'b0, start_in_load: 1'b0, junk_ready: 1'b0};
        vecs[1] = '{frame: 1, early_pix: -1,  wait_dly: -1, dec: 4'd0,  exp_result: 4'hF,  exp_to: 1'b1, start_in_load: 1'b0, junk_ready: 1'b0};
        vecs[2] = '{frame: 2, early_pix: -1,  wait_dly: 0,  dec: 4'd9,  exp_result: 4'd9,  exp_to: 1'b0, start_in_load: 1'b1, junk_ready: 1'b1};
        vecs[3] = '{frame: 3, early_pix: 700, wait_dly: 0,  dec: 4'd7,  exp_result: 4'd7,  exp_to: 1'b0, start_in_load: 1'b0, junk_ready: 1'b0};
        vecs[4] = '{frame: 4, early_pix: -1,  wait_dly: 20, dec: 4'd12, exp_result: 4'd12, exp_to: 1'b0, start_in_load: 1'b0, junk_ready: 1'b0};
        vecs[5] = '{frame: 5, early_pix: 783, wait_dly: 0,  dec: 4'd3,  exp_result: 4'd3,  exp_to: 1'b0, start_in_load: 1'b0, junk_ready: 1'b0};

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset in the middle of a stream.
        load_frame(6, 1'b0, 1'b0);
        start_and_clear();
        for (int k = 0; k <= 300; k++) begin
            if (k > 0) @(negedge clk);
            check_pixel(k);
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("mid_reset_rel");

        run_vec(vecs[3]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
